// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared constants and types for the PE job driver slice
package pe_pkg;

  localparam int DW = 16;
  localparam int NF = 3;
  localparam int ND = 7;
  localparam int NP = ND - NF + 1;

  typedef logic [DW-1:0] filter_row_t [0:NF-1];
  typedef logic [DW-1:0] data_row_t   [0:ND-1];
  typedef logic [DW-1:0] psum_row_t   [0:NP-1];

  typedef struct {
    filter_row_t filter;
    data_row_t   data;
    psum_row_t   psum;
  } job_t;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

endpackage

// File: rtl/pe_job_fifo.sv
// rtl/pe_job_fifo.sv - synchronous job FIFO, reusable by other PE-array feeders
module pe_job_fifo
  import pe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  job_t                     din,
  output job_t                     head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  job_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pe_job_driver.sv
// rtl/pe_job_driver.sv - queues row jobs, launches them on one PE and returns psums
module pe_job_driver
  import pe_pkg::*;
#(
  parameter int JOB_DEPTH = 2,
  parameter int TIMEOUT   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          job_valid,
  output logic          job_ready,
  input  logic [DW-1:0] job_filter [0:NF-1],
  input  logic [DW-1:0] job_data [0:ND-1],
  input  logic [DW-1:0] job_psum [0:NP-1],
  output logic          pe_en,
  output logic [DW-1:0] pe_filter [0:NF-1],
  output logic [DW-1:0] pe_data [0:ND-1],
  output logic [DW-1:0] pe_psum [0:NP-1],
  input  logic          pe_done,
  input  logic [DW-1:0] pe_psum_out [0:NP-1],
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_psum [0:NP-1],
  output logic          res_err,
  output logic          busy,
  output logic          err_sticky
);

  localparam int CW = $clog2(TIMEOUT);

  job_t                        job_in;
  job_t                        head;
  logic                        push;
  logic                        pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(JOB_DEPTH):0]  fifo_count;
  state_t                      state;
  state_t                      state_nxt;
  logic [CW-1:0]               tcnt;
  logic                        timed_out;

  always_comb begin
    job_in.filter = job_filter;
    job_in.data   = job_data;
    job_in.psum   = job_psum;
  end

  assign job_ready = !fifo_full;
  assign push      = job_valid && job_ready;
  assign timed_out = (tcnt == CW'(TIMEOUT - 1));

  pe_job_fifo #(.DEPTH(JOB_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (job_in),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (pe_done || timed_out) state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pe_en     = (state == LAUNCH);
    pop       = (state == WAIT) && (pe_done || timed_out);
    res_valid = (state == RESP);
    busy      = (state != IDLE) || (fifo_count != '0);
  end

  // Operands follow the FIFO head so the PE sees them stable for the whole job.
  always_comb begin
    for (int i = 0; i < NF; i++) pe_filter[i] = fifo_empty ? '0 : head.filter[i];
    for (int i = 0; i < ND; i++) pe_data[i]   = fifo_empty ? '0 : head.data[i];
    for (int i = 0; i < NP; i++) pe_psum[i]   = fifo_empty ? '0 : head.psum[i];
  end

  // A done pulse wins over a same-cycle timeout; a timeout returns the input psums untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt       <= '0;
      res_err    <= 1'b0;
      err_sticky <= 1'b0;
      res_psum   <= '{default: '0};
    end else begin
      if (state == LAUNCH) begin
        tcnt <= '0;
      end else if (state == WAIT) begin
        tcnt <= tcnt + CW'(1);
      end
      if (pop) begin
        for (int i = 0; i < NP; i++) begin
          res_psum[i] <= pe_done ? pe_psum_out[i] : head.psum[i];
        end
        res_err <= !pe_done;
        if (!pe_done) begin
          err_sticky <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_job_driver.sv
// tb/tb_pe_job_driver.sv - self-checking bench for pe_job_driver with a behavioural PE
module tb_pe_job_driver;
  import pe_pkg::*;

  localparam int TO = 32;

  typedef struct packed {
    logic [NF-1:0][DW-1:0] f;
    logic [ND-1:0][DW-1:0] d;
    logic [NP-1:0][DW-1:0] p;
  } tjob_t;

  typedef struct packed {
    logic [NP-1:0][DW-1:0] psum;
    logic                  err;
  } tres_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [DW-1:0] job_filter [0:NF-1];
  logic [DW-1:0] job_data [0:ND-1];
  logic [DW-1:0] job_psum [0:NP-1];
  logic          pe_en;
  logic [DW-1:0] pe_filter [0:NF-1];
  logic [DW-1:0] pe_data [0:ND-1];
  logic [DW-1:0] pe_psum [0:NP-1];
  logic          pe_done = 1'b0;
  logic [DW-1:0] pe_psum_out [0:NP-1];
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [DW-1:0] res_psum [0:NP-1];
  logic          res_err;
  logic          busy;
  logic          err_sticky;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_en = 0;
  int last_en = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pe_job_driver #(.JOB_DEPTH(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_filter(job_filter), .job_data(job_data), .job_psum(job_psum),
    .pe_en(pe_en), .pe_filter(pe_filter), .pe_data(pe_data), .pe_psum(pe_psum),
    .pe_done(pe_done), .pe_psum_out(pe_psum_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_psum(res_psum), .res_err(res_err),
    .busy(busy), .err_sticky(err_sticky)
  );

  task automatic chk(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic tjob_t mk(input int fb, input int db, input int pm);
    tjob_t j;
    for (int i = 0; i < NF; i++) j.f[i] = DW'(fb + i);
    for (int i = 0; i < ND; i++) j.d[i] = DW'(db + i);
    for (int i = 0; i < NP; i++) j.p[i] = DW'(pm * (i + 1));
    return j;
  endfunction

  function automatic tjob_t ops();
    tjob_t j;
    for (int i = 0; i < NF; i++) j.f[i] = pe_filter[i];
    for (int i = 0; i < ND; i++) j.d[i] = pe_data[i];
    for (int i = 0; i < NP; i++) j.p[i] = pe_psum[i];
    return j;
  endfunction

  function automatic logic [NP-1:0][DW-1:0] rpsum();
    logic [NP-1:0][DW-1:0] r;
    for (int i = 0; i < NP; i++) r[i] = res_psum[i];
    return r;
  endfunction

  function automatic logic [NP-1:0][DW-1:0] plus1(input tjob_t j);
    logic [NP-1:0][DW-1:0] r;
    for (int i = 0; i < NP; i++) r[i] = j.d[i] + DW'(1);
    return r;
  endfunction

  // Behavioural PE: answers data[i]+1 pe_lat cycles after pe_en; pe_lat=0 never answers.
  int    pe_lat = 7;
  int    pe_timer = -1;
  tjob_t pe_job;

  task automatic pe_step();
    pe_done = 1'b0;
    if (pe_timer > 0) begin
      pe_timer--;
      if (pe_timer == 0) begin
        pe_done = 1'b1;
        for (int i = 0; i < NP; i++) pe_psum_out[i] = pe_job.d[i] + DW'(1);
        pe_timer = -1;
      end
    end
    if (pe_en) begin
      pe_job   = ops();
      pe_timer = (pe_lat > 0) ? pe_lat : -1;
    end
  endtask

  // Reference model: jobs queued, job in flight, results awaiting handshake.
  tjob_t jq[$];
  tres_t rq[$];
  tjob_t drv_job;
  tjob_t fj;
  tres_t rtmp;
  bit    infl = 1'b0;
  bit    sticky_m = 1'b0;
  bit    prev_en = 1'b0;
  int    wcnt = 0;

  always @(negedge clk) begin
    pe_step();
    chk(job_ready === ((jq.size() + int'(infl)) < 2), "job_ready", 256'(job_ready), 256'((jq.size() + int'(infl)) < 2));
    chk(busy === (jq.size() > 0 || infl || rq.size() > 0), "busy", 256'(busy), 256'(jq.size() > 0 || infl || rq.size() > 0));
    chk(res_valid === (rq.size() > 0), "res_valid", 256'(res_valid), 256'(rq.size() > 0));
    chk(err_sticky === sticky_m, "err_sticky", 256'(err_sticky), 256'(sticky_m));
    if (res_valid && rq.size() > 0) begin
      chk(rpsum() === rq[0].psum, "res_psum", 256'(rpsum()), 256'(rq[0].psum));
      chk(res_err === rq[0].err, "res_err", 256'(res_err), 256'(rq[0].err));
    end
    if (pe_en) begin
      n_en++;
      chk(!prev_en && !infl && rq.size() == 0 && jq.size() > 0, "pe_en_allowed", 256'(pe_en), 256'(0));
      if (jq.size() > 0) chk(ops() === jq[0], "launch_operands", 256'(ops()), 256'(jq[0]));
      if (last_en >= 0) chk(cyc - last_en >= 9, "pe_en_gap", 256'(cyc - last_en), 256'(9));
      last_en = cyc;
    end
    if (infl) chk(ops() === fj, "operands_held", 256'(ops()), 256'(fj));

    if (rst) begin
      jq.delete();
      rq.delete();
      infl = 1'b0;
      sticky_m = 1'b0;
    end else begin
      if (infl) begin
        wcnt++;
        if (pe_done || wcnt == TO) begin
          rtmp.err  = !pe_done;
          rtmp.psum = pe_done ? plus1(fj) : fj.p;
          rq.push_back(rtmp);
          sticky_m = sticky_m | rtmp.err;
          infl = 1'b0;
        end
      end
      if (pe_en && jq.size() > 0) begin
        fj   = jq.pop_front();
        infl = 1'b1;
        wcnt = 0;
      end
      if (res_valid && res_ready && rq.size() > 0) void'(rq.pop_front());
      if (job_valid && job_ready) jq.push_back(drv_job);
    end
    prev_en = pe_en;
  end

  task automatic push_job(input tjob_t j);
    bit ok;
    @(posedge clk); #1;
    drv_job = j;
    for (int i = 0; i < NF; i++) job_filter[i] = j.f[i];
    for (int i = 0; i < ND; i++) job_data[i] = j.d[i];
    for (int i = 0; i < NP; i++) job_psum[i] = j.p[i];
    job_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (job_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk(ok, "push_accepted", 256'(ok), 256'(1));
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic wait_res(output int c);
    c = -1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (res_valid) begin
        c = cyc;
        break;
      end
    end
    chk(c >= 0, "wait_res_bound", 256'(c), 256'(0));
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (!busy && !res_valid && !job_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(ok, "wait_idle_bound", 256'(ok), 256'(1));
  endtask

  initial begin
    int c;
    int n0;
    logic [NP-1:0][DW-1:0] exp_p;
    tjob_t j;
    for (int i = 0; i < NF; i++) job_filter[i] = '0;
    for (int i = 0; i < ND; i++) job_data[i] = '0;
    for (int i = 0; i < NP; i++) job_psum[i] = '0;
    for (int i = 0; i < NP; i++) pe_psum_out[i] = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(job_ready === 1'b1 && res_valid === 1'b0 && busy === 1'b0 && pe_en === 1'b0 && err_sticky === 1'b0,
        "reset_flags", 256'({job_ready, res_valid, busy, pe_en, err_sticky}), 256'(5'b10000));
    chk(rpsum() === '0 && ops() === '0, "reset_zero_data", 256'(ops()), 256'(0));

    // single job: filter {1,2,3}, data 1..7, psum 0 -> {2,3,4,5,6}
    n0 = n_en;
    push_job(mk(1, 1, 0));
    wait_res(c);
    exp_p = {16'd6, 16'd5, 16'd4, 16'd3, 16'd2};
    chk(rpsum() === exp_p, "single_psum", 256'(rpsum()), 256'(exp_p));
    chk(res_err === 1'b0, "single_err", 256'(res_err), 256'(0));
    chk(c - last_en == 8, "single_latency", 256'(c - last_en), 256'(8));
    wait_idle();
    chk(n_en - n0 == 1 && busy === 1'b0, "single_one_pulse", 256'(n_en - n0), 256'(1));

    // back-to-back: third push stalls while the FIFO is full
    n0 = n_en;
    push_job(mk(10, 100, 1));
    push_job(mk(20, 200, 2));
    @(negedge clk);
    chk(job_ready === 1'b0, "full_ready_low", 256'(job_ready), 256'(0));
    push_job(mk(30, 300, 3));
    wait_idle();
    chk(n_en - n0 == 3, "b2b_pulses", 256'(n_en - n0), 256'(3));

    // backpressure with a second job queued behind the held result
    res_ready = 1'b0;
    push_job(mk(40, 400, 4));
    push_job(mk(50, 500, 5));
    wait_res(c);
    n0 = n_en;
    repeat (20) @(negedge clk);
    chk(n_en == n0 && res_valid === 1'b1, "bp_hold", 256'(n_en - n0), 256'(0));
    @(posedge clk); #1 res_ready = 1'b1;
    wait_idle();

    // timeout: PE never answers, input psums come back flagged
    pe_lat = 0;
    push_job(mk(3, 9, 10));
    wait_res(c);
    exp_p = {16'd50, 16'd40, 16'd30, 16'd20, 16'd10};
    chk(rpsum() === exp_p, "timeout_psum", 256'(rpsum()), 256'(exp_p));
    chk(res_err === 1'b1 && err_sticky === 1'b1, "timeout_err", 256'({res_err, err_sticky}), 256'(2'b11));
    chk(c - last_en == 33, "timeout_latency", 256'(c - last_en), 256'(33));
    wait_idle();
    pe_lat = 7;
    push_job(mk(5, 60, 0));
    wait_res(c);
    chk(res_err === 1'b0 && err_sticky === 1'b1, "after_timeout", 256'({res_err, err_sticky}), 256'(2'b01));
    wait_idle();

    // done arrives on the final WAIT cycle: done wins
    pe_lat = 32;
    j = mk(7, 1000, 9);
    push_job(j);
    wait_res(c);
    chk(res_err === 1'b0, "collision_err", 256'(res_err), 256'(0));
    chk(rpsum() === plus1(j), "collision_psum", 256'(rpsum()), 256'(plus1(j)));
    chk(c - last_en == 33, "collision_latency", 256'(c - last_en), 256'(33));
    wait_idle();

    // reset while waiting; the late done must be ignored
    pe_lat = 7;
    push_job(mk(2, 70, 1));
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (pe_en) break;
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    n0 = n_en;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      chk(res_valid === 1'b0, "rst_no_result", 256'(res_valid), 256'(0));
    end
    chk(job_ready === 1'b1 && busy === 1'b0 && n_en == n0 && err_sticky === 1'b0,
        "rst_empty", 256'({job_ready, busy, err_sticky}), 256'(3'b100));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
